// File: rtl/two_pulse_wide_inc_counter_pkg.sv
// Shared defaults for the pulse-qualified event counter.
// Holds the common width constants and the run-length sizing helper.
package two_pulse_wide_inc_counter_pkg;

  localparam int CNT_W_DEF   = 4;
  localparam int PULSE_W_DEF = 2;

  // Run length must reach PULSE_W+1 ("too long").
  function automatic int run_w(input int pw);
    return $clog2(pw + 2);
  endfunction

endpackage

// File: rtl/two_pulse_wide_inc_counter.sv
// Counts inc pulses that are exactly PULSE_W samples wide.
// Counting happens at the first low sample after the pulse.
module two_pulse_wide_inc_counter
  import two_pulse_wide_inc_counter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PULSE_W = PULSE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam int RUN_W = run_w(PULSE_W);

  localparam logic [RUN_W-1:0] RUN_HIT =
    RUN_W'(PULSE_W);
  localparam logic [RUN_W-1:0] RUN_MAX =
    RUN_W'(PULSE_W + 1);

  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;
  logic             w_sat;

  assign w_hit = !inc && (r_run == RUN_HIT);
  assign w_sat = (r_run == RUN_MAX);

  // Track the high run length, saturating at too-long.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= '0;
    end else if (inc) begin
      if (!w_sat) r_run <= r_run + 1'b1;
    end else begin
      r_run <= '0;
    end
  end

  // Bump the wrapping count on a qualified falling sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_hit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: tb/tb_two_pulse_wide_inc_counter.sv
// Bench for two_pulse_wide_inc_counter.
// Directed plan cases plus random pulse trains against a model.
module tb_two_pulse_wide_inc_counter;

  localparam int CW = 4;
  localparam int PW = 2;

  logic          clk;
  logic          rst;
  logic          inc;
  logic [CW-1:0] cnt;

  int n_cmp;
  int n_err;
  int m_cnt;
  int m_high;

  two_pulse_wide_inc_counter #(
    .CNT_W  (CW),
    .PULSE_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inc(inc),
    .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  // One clock: drive, apply the rule to the model, compare.
  task automatic step(input bit r, input bit i);
    @(negedge clk);
    rst = r;
    inc = i;
    @(posedge clk);
    if (r) begin
      m_cnt  = 0;
      m_high = 0;
    end else if (i) begin
      m_high++;
    end else begin
      if (m_high == PW)
        m_cnt = (m_cnt + 1) % (1 << CW);
      m_high = 0;
    end
    #1;
    chk("cnt", int'(cnt), m_cnt);
  endtask

  task automatic pulse(input int w);
    for (int k = 0; k < w; k++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    m_cnt  = 0;
    m_high = 0;
    rst    = 1'b1;
    inc    = 1'b0;

    // reset then idle
    step(1'b1, 1'b0);
    chk("rst", int'(cnt), 0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
    chk("idle", int'(cnt), 0);

    // single pulse: count lands on the low sample
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("pre_low", int'(cnt), 0);
    step(1'b0, 1'b0);
    chk("single", int'(cnt), 1);
    step(1'b0, 1'b0);
    chk("single_hold", int'(cnt), 1);

    // 30 back-to-back pulses with wrap
    step(1'b1, 1'b0);
    for (int p = 1; p <= 30; p++) begin
      pulse(PW);
      if (p == 15) chk("bb_15", int'(cnt), 15);
      if (p == 16) chk("bb_wrap", int'(cnt), 0);
    end
    chk("bb_end", int'(cnt), 14);

    // too long and too short pulses
    pulse(6);
    chk("long6", int'(cnt), 14);
    pulse(1);
    chk("short1", int'(cnt), 14);
    pulse(3);
    chk("long3", int'(cnt), 14);

    // reset mid-pulse discards prior highs
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("rst_mid", int'(cnt), 0);
    pulse(PW);
    chk("after_rst", int'(cnt), 1);

    // preload to 15, wrap to 0
    step(1'b1, 1'b0);
    for (int p = 0; p < 15; p++) pulse(PW);
    chk("pre15", int'(cnt), 15);
    pulse(PW);
    chk("wrap0", int'(cnt), 0);

    // reset on the qualifying low sample
    for (int p = 0; p < 3; p++) pulse(PW);
    chk("pre_rq", int'(cnt), 3);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("rst_q", int'(cnt), 0);
    step(1'b0, 1'b0);
    chk("run_clr", int'(cnt), 0);

    // random pulse trains with occasional reset
    for (int n = 0; n < 600; n++) begin
      int w;
      int g;
      w = $urandom_range(0, 4);
      g = $urandom_range(1, 2);
      for (int k = 0; k < w; k++)
        step(($urandom_range(0, 63) == 0), 1'b1);
      for (int k = 0; k < g; k++)
        step(($urandom_range(0, 63) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
